// File: rtl/scs8hd_oai22_bist_ctl.sv
// Self-test controller for an scs8hd o22ai cell: an LFSR drives A1/A2/B1/B2, and a MISR compacts Y.
// Optional feature macro SCS8HD_BIST_ERRCNT_EN adds a per-pattern model compare with an ERR_COUNT output.
module scs8hd_oai22_bist_ctl #(
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter int          NUM_PATTERNS = 255,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        START,
  input  logic        Y_IN,
  output logic        A1,
  output logic        A2,
  output logic        B1,
  output logic        B2,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIGNATURE,
`ifdef SCS8HD_BIST_ERRCNT_EN
  output logic [7:0]  ERR_COUNT,
`endif
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0] LAST = 8'(NUM_PATTERNS - 1);

  state_t      state, state_n;
  logic [7:0]  lfsr, lfsr_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  stim, stim_n;
  logic [15:0] sig, sig_n;
  logic        pass_q, pass_n;

  logic [7:0]  lfsr_step;
  logic [15:0] misr_next;
  logic        sig_ok;

  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // Y_IN is the cell's response to the stimulus registered at the previous edge.
  assign misr_next = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, Y_IN};

`ifdef SCS8HD_BIST_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt_n;
  logic       y_model;
  logic       mismatch;

  assign y_model  = ~((stim[3] | stim[2]) & (stim[1] | stim[0]));
  assign mismatch = (Y_IN != y_model);
  assign sig_ok   = (misr_next == GOLDEN_SIG) && (err_cnt == 8'h00) && !mismatch;
`else
  assign sig_ok   = (misr_next == GOLDEN_SIG);
`endif

  // START is a level: a start edge is any edge seen in IDLE or DONE with START high.
  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    stim_n  = stim;
    sig_n   = sig;
    pass_n  = pass_q;
`ifdef SCS8HD_BIST_ERRCNT_EN
    err_cnt_n = err_cnt;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_n = ST_RUN;
          lfsr_n  = SEED;
          cnt_n   = 8'h00;
          stim_n  = SEED[3:0];
          sig_n   = 16'hFFFF;
          pass_n  = 1'b0;
`ifdef SCS8HD_BIST_ERRCNT_EN
          err_cnt_n = 8'h00;
`endif
        end
      end
      ST_RUN: begin
        sig_n = misr_next;
`ifdef SCS8HD_BIST_ERRCNT_EN
        if (mismatch && (err_cnt != 8'hFF)) err_cnt_n = err_cnt + 8'd1;
`endif
        if (cnt != LAST) begin
          cnt_n  = cnt + 8'd1;
          lfsr_n = lfsr_step;
          stim_n = lfsr_step[3:0];
        end else begin
          state_n = ST_DONE;
          pass_n  = sig_ok;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state  <= ST_IDLE;
      lfsr   <= SEED;
      cnt    <= 8'h00;
      stim   <= 4'h0;
      sig    <= 16'hFFFF;
      pass_q <= 1'b0;
`ifdef SCS8HD_BIST_ERRCNT_EN
      err_cnt <= 8'h00;
`endif
    end else begin
      state  <= state_n;
      lfsr   <= lfsr_n;
      cnt    <= cnt_n;
      stim   <= stim_n;
      sig    <= sig_n;
      pass_q <= pass_n;
`ifdef SCS8HD_BIST_ERRCNT_EN
      err_cnt <= err_cnt_n;
`endif
    end
  end

  assign {A1, A2, B1, B2} = stim;
  assign BUSY      = (state == ST_RUN);
  assign DONE      = (state == ST_DONE);
  assign PASS      = pass_q;
  assign SIGNATURE = sig;
  assign fsm_state = state;
`ifdef SCS8HD_BIST_ERRCNT_EN
  assign ERR_COUNT = err_cnt;
`endif

endmodule

// File: tb/tb_scs8hd_oai22_bist_ctl.sv
// Directed bench for scs8hd_oai22_bist_ctl: a 255-pattern instance on a modelled o22ai cell
// and a single-pattern instance with Y tied high.
module tb_scs8hd_oai22_bist_ctl;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic y);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, y};
  endfunction

  function automatic logic o22ai(input logic [3:0] s);
    return ~((s[3] | s[2]) & (s[1] | s[0]));
  endfunction

  function automatic logic [15:0] model_sig(input logic [7:0] seed, input int n, input bit stuck);
    logic [15:0] s;
    logic [7:0]  l;
    s = 16'hFFFF;
    l = seed;
    for (int k = 0; k < n; k++) begin
      s = misr_step(s, stuck ? 1'b0 : o22ai(l[3:0]));
      l = lfsr_step(l);
    end
    return s;
  endfunction

  function automatic int model_ones(input logic [7:0] seed, input int n);
    logic [7:0] l;
    int         c;
    l = seed;
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (o22ai(l[3:0])) c++;
      l = lfsr_step(l);
    end
    return c;
  endfunction

  localparam logic [15:0] GOLDEN = model_sig(8'hA5, 255, 1'b0);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, start_b, stuck;
  logic        a1_a, a2_a, b1_a, b2_a, busy_a, done_a, pass_a, y_a;
  logic        a1_b, a2_b, b1_b, b2_b, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;
  logic [1:0]  st_a, st_b;
`ifdef SCS8HD_BIST_ERRCNT_EN
  logic [7:0]  err_a, err_b;
`endif

  assign y_a = stuck ? 1'b0 : o22ai({a1_a, a2_a, b1_a, b2_a});

  scs8hd_oai22_bist_ctl #(
    .LFSR_SEED(8'hA5), .NUM_PATTERNS(255), .GOLDEN_SIG(GOLDEN)
  ) dut_a (
    .CLK(clk), .RESETB(rst_n), .START(start_a), .Y_IN(y_a),
    .A1(a1_a), .A2(a2_a), .B1(b1_a), .B2(b2_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIGNATURE(sig_a),
`ifdef SCS8HD_BIST_ERRCNT_EN
    .ERR_COUNT(err_a),
`endif
    .fsm_state(st_a)
  );

  scs8hd_oai22_bist_ctl #(
    .LFSR_SEED(8'hA5), .NUM_PATTERNS(1), .GOLDEN_SIG(16'h0000)
  ) dut_b (
    .CLK(clk), .RESETB(rst_n), .START(start_b), .Y_IN(1'b1),
    .A1(a1_b), .A2(a2_b), .B1(b1_b), .B2(b2_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIGNATURE(sig_b),
`ifdef SCS8HD_BIST_ERRCNT_EN
    .ERR_COUNT(err_b),
`endif
    .fsm_state(st_b)
  );

  // scoreboard
  int         checks_done = 0;
  int         fail_count  = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input bit stuck_mode, input string tag);
    logic [7:0] l;
    logic [3:0] last_nib;
    logic [3:0] exp_nib;
    int         cycles, stim_err, distinct;
    bit         seen[256];
    logic [15:0] exp_sig;
    stuck = stuck_mode;
    exp_sig = model_sig(8'hA5, 255, stuck_mode);
    exp_q.delete();
    l = 8'hA5;
    last_nib = 4'h0;
    for (int k = 0; k < 255; k++) begin
      exp_q.push_back(l[3:0]);
      last_nib = l[3:0];
      l = lfsr_step(l);
    end
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({tag, "_sig_init"}, 32'(sig_a), 32'hFFFF);
    cycles = 0;
    stim_err = 0;
    while (busy_a && cycles < 400) begin
      if (exp_q.size() == 0) stim_err++;
      else begin
        exp_nib = exp_q.pop_front();
        if ({a1_a, a2_a, b1_a, b2_a} != exp_nib) stim_err++;
      end
      seen[dut_a.lfsr] = 1'b1;
      start_a = (cycles == 50);
      tick();
      cycles++;
    end
    start_a = 1'b0;
    distinct = 0;
    for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
    check({tag, "_done_edge"}, 32'(cycles + 1), 32'd256);
    check({tag, "_stim_seq"}, 32'(stim_err), 32'd0);
    check({tag, "_lfsr_states"}, 32'(distinct), 32'd255);
    check({tag, "_done"}, {30'b0, busy_a, done_a}, 32'b01);
    check({tag, "_sig"}, 32'(sig_a), 32'(exp_sig));
    check({tag, "_pass"}, 32'(pass_a), 32'(exp_sig == GOLDEN));
    check({tag, "_stim_hold"}, 32'({a1_a, a2_a, b1_a, b2_a}), 32'(last_nib));
`ifdef SCS8HD_BIST_ERRCNT_EN
    check({tag, "_errcnt"}, 32'(err_a), stuck_mode ? 32'(model_ones(8'hA5, 255)) : 32'd0);
`endif
    tick();
    check({tag, "_done_hold"}, {done_a, pass_a, sig_a}, {1'b1, exp_sig == GOLDEN, exp_sig});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    stuck = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_stim", 32'({a1_a, a2_a, b1_a, b2_a}), 32'h0);
    check("rst_flags", {29'b0, busy_a, done_a, pass_a}, 32'b000);
    check("rst_sig", 32'(sig_a), 32'hFFFF);
    check("rst_state", 32'(st_a), 32'd0);
    check("rst_sig_b", 32'(sig_b), 32'hFFFF);
    rst_n = 1'b1;
    tick();

    // single pattern, Y tied high
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("np1_stim", 32'({a1_b, a2_b, b1_b, b2_b}), 32'b0101);
    check("np1_busy", {30'b0, busy_b, done_b}, 32'b10);
    tick();
    check("np1_done", {30'b0, busy_b, done_b}, 32'b01);
    check("np1_sig", 32'(sig_b), 32'hEFDE);
    check("np1_pass", 32'(pass_b), 32'd0);
    check("np1_state", 32'(st_b), 32'd2);
    tick();
    check("np1_hold", {done_b, sig_b, a1_b, a2_b, b1_b, b2_b}, {1'b1, 16'hEFDE, 4'b0101});

    // full run on a good cell, then a stuck-at-0 cell
    run_full(1'b0, "good");
    run_full(1'b1, "stuck0");

    // reset in the middle of a run, with START high to show reset priority
    stuck = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (100) tick();
    check("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    start_a = 1'b1;
    tick();
    check("mid_rst_state", 32'(st_a), 32'd0);
    check("mid_rst_outs", {busy_a, done_a, pass_a, a1_a, a2_a, b1_a, b2_a}, 32'd0);
    check("mid_rst_sig", 32'(sig_a), 32'hFFFF);
    rst_n = 1'b1;
    start_a = 1'b0;
    tick();
    check("mid_idle_hold", 32'(st_a), 32'd0);
    run_full(1'b0, "after_rst");

    // START held high on the single-pattern instance
    start_b = 1'b1;
    tick();
    check("hold_run1", {30'b0, busy_b, done_b}, 32'b10);
    tick();
    check("hold_done1", {busy_b, done_b, sig_b}, {2'b01, 16'hEFDE});
    tick();
    check("hold_rerun", {busy_b, done_b, sig_b}, {2'b10, 16'hFFFF});
    tick();
    check("hold_done2", {30'b0, busy_b, done_b}, 32'b01);
    start_b = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
